// File: rtl/fp4_to_fp6_unpacker_if.sv
// Stream bundle between the FP4 word source, the unpacker and the FP6 lane sink.
// Handshake: a beat transfers on the rising edge where valid && ready; the sender holds its payload until then.
interface fp4_to_fp6_unpacker_if #(
  parameter int LANES = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*LANES-1:0]   in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [5:0]           out_data;
  logic                 out_special;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_special, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_special, out_last
  );
endinterface

// File: rtl/fp4_to_fp6_unpacker.sv
// Unpacks words of LANES FP4 codes into one exact FP6 element per cycle, lane 0 first,
// and keeps a saturating count of Inf/NaN elements delivered downstream.
module fp4_to_fp6_unpacker #(
  parameter int LANES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fp4_to_fp6_unpacker_if.slave       bus,
  input  logic                       clr_count,
  output logic [15:0]                special_count
);
  localparam int IW = $clog2(LANES);

  logic [4*LANES-1:0] r_hold;
  logic               r_last;
  logic               r_loaded;
  logic [IW-1:0]      r_idx;
  logic [15:0]        r_cnt;

  logic [4*LANES-1:0] w_shift;
  logic [3:0]         w_code;
  logic               w_idx_end;
  logic               w_out_fire;
  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_special;
  logic [5:0]         w_fp6;

  assign w_shift    = r_hold >> {r_idx, 2'b00};
  assign w_code     = w_shift[3:0];
  assign w_idx_end  = (r_idx == IW'(LANES - 1));
  assign w_out_fire = r_loaded & bus.out_ready;
  // The last lane draining frees the holding register in the same cycle, so words stream without a bubble.
  assign w_in_ready = ~r_loaded | (w_out_fire & w_idx_end);
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_special  = (w_code[2:1] == 2'b11);

  always_comb begin
    w_fp6 = {w_code, 2'b00};
    if (w_special) begin
      w_fp6 = w_code[0] ? {w_code[3], 5'b11100} : {w_code[3], 5'b11000};
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_loaded;
  assign bus.out_data    = w_fp6;
  assign bus.out_special = r_loaded & w_special;
  assign bus.out_last    = r_loaded & r_last & w_idx_end;
  assign special_count   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold   <= '0;
      r_last   <= 1'b0;
      r_loaded <= 1'b0;
      r_idx    <= '0;
    end else if (w_in_fire) begin
      r_hold   <= bus.in_data;
      r_last   <= bus.in_last;
      r_loaded <= 1'b1;
      r_idx    <= '0;
    end else if (w_out_fire) begin
      if (w_idx_end) begin
        r_idx    <= '0;
        r_loaded <= 1'b0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // Clear wins over a simultaneous special transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_count) begin
      r_cnt <= '0;
    end else if (w_out_fire && w_special && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fp4_to_fp6_unpacker.sv
// Directed bench for fp4_to_fp6_unpacker: reference conversion, expected-element queue,
// handshake/stall checks and a saturating-counter reference.
module tb_fp4_to_fp6_unpacker;
  localparam int LANES = 8;
  localparam int W     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_count = 1'b0;
  logic [15:0] special_count;

  fp4_to_fp6_unpacker_if #(.LANES(LANES)) bus ();

  fp4_to_fp6_unpacker #(.LANES(LANES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .clr_count     (clr_count),
    .special_count (special_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_fp6(input logic [3:0] c);
    if (c[2:1] != 2'b11) return {c, 2'b00};
    return c[0] ? {c[3], 5'b11100} : {c[3], 5'b11000};
  endfunction

  // FP6 -> FP4 narrowing with round-to-nearest-even; exponent 11 maps to Inf.
  function automatic logic [3:0] ref_round(input logic [5:0] f);
    logic       up;
    logic [2:0] mag;
    if (f[4:3] == 2'b11) return {f[5], 3'b110};
    up  = f[1] & (f[0] | f[2]);
    mag = {f[4:3], f[2]} + {2'b00, up};
    return {f[5], mag};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [5:0]   obs_q[$];
  logic [W-1:0] exp_e;
  logic [3:0]   mon_code;
  logic [15:0]  exp_cnt = 16'd0;
  logic [5:0]   held = 6'd0;
  logic         stalled = 1'b0;
  logic         spec_xfer;
  logic         capture = 1'b0;
  int           tb_lane = 0;
  int           cyc = 0;
  int           win_valid = 0, win_ready = 0, win_last = 0, first_v = -1, last_v = -1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      tb_lane = 0;
      exp_cnt = 16'd0;
      stalled = 1'b0;
    end else begin
      check("special_count", special_count, exp_cnt);
      check("in_ready", bus.in_ready, !bus.out_valid || (bus.out_ready && tb_lane == LANES-1));
      if (stalled && bus.out_valid) check("stall_hold", bus.out_data, held);
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.out_valid) begin
        win_valid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (bus.in_ready) win_ready++;
        if (bus.out_last) win_last++;
      end
      spec_xfer = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", bus.out_valid, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_data", bus.out_data, exp_e[5:0]);
          check("out_special", bus.out_special, exp_e[6]);
          check("out_last", bus.out_last, exp_e[7]);
          spec_xfer = exp_e[6];
        end
        if (capture) obs_q.push_back(bus.out_data);
        tb_lane = (tb_lane == LANES-1) ? 0 : tb_lane + 1;
      end
      if (clr_count) exp_cnt = 16'd0;
      else if (spec_xfer && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (bus.in_valid && bus.in_ready) begin
        for (int k = 0; k < LANES; k++) begin
          mon_code = bus.in_data[4*k +: 4];
          exp_q.push_back({(k == LANES-1) && bus.in_last, mon_code[2:1] == 2'b11, ref_fp6(mon_code)});
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  logic rand_ready = 1'b0;
  logic ready_level = 1'b1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [4*LANES-1:0] d, input logic last);
    int t;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 200);
    if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (bus.out_valid) check("drain_timeout", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_window();
    win_valid = 0; win_ready = 0; win_last = 0; first_v = -1; last_v = -1;
  endtask

  // ---------------- directed sequence ----------------
  logic [5:0] gold [16] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C,
                            6'h20, 6'h24, 6'h28, 6'h2C, 6'h30, 6'h34, 6'h38, 6'h3C};
  logic [3:0] rt_exp;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_special", bus.out_special, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_special_count", special_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Every code once, then the round trip through the narrowing rounder.
    capture = 1'b1;
    send_word(32'h76543210, 1'b0);
    send_word(32'hFEDCBA98, 1'b0);
    idle();
    drain();
    capture = 1'b0;
    check("map_count", obs_q.size(), 16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      check($sformatf("map_%0d", i), obs_q[i], gold[i]);
      rt_exp = 4'(i);
      if (rt_exp[2:0] == 3'b111) rt_exp = {rt_exp[3], 3'b110};
      check($sformatf("round_trip_%0d", i), ref_round(obs_q[i]), rt_exp);
    end
    check("map_special_count", special_count, 4);

    // Back-to-back words, the second flagged last.
    clear_window();
    send_word(32'h13579BDF, 1'b0);
    send_word(32'h02468ACE, 1'b1);
    idle();
    drain();
    check("b2b_valid_cycles", win_valid, 16);
    check("b2b_span", last_v - first_v, 15);
    check("b2b_in_ready_pulses", win_ready, 2);
    check("b2b_last_count", win_last, 1);

    // Random backpressure.
    rand_ready = 1'b1;
    send_word(32'hF0E1D2C3, 1'b0);
    send_word(32'h8796A5B4, 1'b0);
    send_word(32'h6E7F0123, 1'b1);
    send_word(32'h4567CDEF, 1'b0);
    idle();
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-word at index 3.
    send_word(32'hA5A56E71, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_special_count", special_count, 0);
    check("midrst_out_last", bus.out_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Saturation: 70000 special elements.
    for (int i = 0; i < 8750; i++) send_word(32'h66666666, 1'b0);
    idle();
    drain();
    check("sat_special_count", special_count, 16'hFFFF);

    // Clear coinciding with a special transfer.
    send_word(32'h66666666, 1'b0);
    idle();
    check("pre_clr_count", special_count, 16'hFFFF);
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    check("clr_with_xfer", special_count, 0);
    drain();
    check("post_clr_count", special_count, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
